instr_fetch_unit: RTL

Instruction fetch stage of the 19-bit CPU, directly upstream of `control_unit`. It owns the program counter and instruction register, runs a request/acknowledge read against instruction memory on demand, and presents the fetched word and its opcode to the control unit. It also handles jump/branch redirects and flags a fault when memory fails to answer.

---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/program_counter.sv | 30 +++
 rtl/instr_fetch_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared across the 19-bit CPU front end.
//   - instruction and opcode field geometry
//   - fetch-stage state encoding
//   - opcode values decoded by control_unit
package cpu_pkg;

  localparam int INSTR_W  = 19;
  localparam int OPCODE_W = 5;

  // Opcode field position inside an instruction word
  localparam int OPC_MSB = 18;
  localparam int OPC_LSB = 14;

  // Literals carry an FS_ prefix so they never collide with port names
  // such as FAULT in the modules that import this package.
  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_WAIT  = 2'd1,
    FS_FAULT = 2'd2
  } fetch_state_t;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP  = 5'h00,
    OP_ADD  = 5'h01,
    OP_SUB  = 5'h02,
    OP_AND  = 5'h03,
    OP_OR   = 5'h04,
    OP_XOR  = 5'h05,
    OP_SHL  = 5'h06,
    OP_SHR  = 5'h07,
    OP_ADDI = 5'h08,
    OP_LDI  = 5'h09,
    OP_LD   = 5'h0A,
    OP_ST   = 5'h0B,
    OP_MOV  = 5'h0C,
    OP_CMP  = 5'h0D,
    OP_JMP  = 5'h10,
    OP_JZ   = 5'h11,
    OP_JNZ  = 5'h12,
    OP_CALL = 5'h13,
    OP_RET  = 5'h14,
    OP_HLT  = 5'h1F
  } opcode_t;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/program_counter.sv
// program_counter: ADDR_W-bit PC register.
//   CLK      - clock, rising edge
//   RST      - synchronous active-high reset, loads RESET_VEC
//   load     - load load_val (highest priority after reset)
//   load_val - load target
//   inc      - advance by one, wrapping modulo 2^ADDR_W
//   pc       - current value; holds when neither load nor inc
module program_counter #(
  parameter int                ADDR_W    = 19,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc <= RESET_VEC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage feeding control_unit.
// Owns PC and IR, performs a req/ack read from instruction memory on
// demand, handles redirects (LOAD_PC) and raises a sticky FAULT when
// memory does not answer within TIMEOUT wait cycles (0 disables it).
// Ports:
//   CLK, RST            - clock, synchronous active-high reset
//   EN                  - gates FETCH/LOAD_PC acceptance in IDLE
//   FETCH, LOAD_PC      - fetch request, redirect strobe
//   PC_IN               - redirect target
//   IMEM_REQ, IMEM_ADDR - memory read request and address
//   IMEM_ACK, IMEM_RDATA- memory answer
//   IR, OPCODE, IR_PC   - fetched word, its opcode, its address
//   PC                  - next fetch address
//   INSTR_VALID         - IR holds an unconsumed instruction
//   BUSY                - access outstanding
//   FAULT               - memory timeout (sticky until RST)
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = 19,
  parameter int                INSTR_W   = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                TIMEOUT   = 15
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                FETCH,
  input  logic                LOAD_PC,
  input  logic [ADDR_W-1:0]   PC_IN,
  output logic                IMEM_REQ,
  output logic [ADDR_W-1:0]   IMEM_ADDR,
  input  logic                IMEM_ACK,
  input  logic [INSTR_W-1:0]  IMEM_RDATA,
  output logic [INSTR_W-1:0]  IR,
  output logic [OPCODE_W-1:0] OPCODE,
  output logic [ADDR_W-1:0]   IR_PC,
  output logic [ADDR_W-1:0]   PC,
  output logic                INSTR_VALID,
  output logic                BUSY,
  output logic                FAULT
);

  // Wide enough to hold TIMEOUT itself, never narrower than one bit
  localparam int              CNT_W   = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  fetch_state_t      state;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              pend_vld;
  logic [ADDR_W-1:0] pend_pc;

  logic              pc_load;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc_d;

  // A redirect seen during the access (earlier or on the ACK cycle)
  // means the returning word belongs to the abandoned path.
  logic              drop_data;

  assign drop_data = pend_vld | LOAD_PC;
  assign OPCODE    = IR[OPC_MSB:OPC_LSB];

  // PC update: redirects load, a clean ACK increments, otherwise hold.
  // A same-cycle PC_IN outranks the pending target.
  always_comb begin
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    pc_d    = PC_IN;
    case (state)
      FS_IDLE: begin
        if (EN && LOAD_PC) pc_load = 1'b1;
      end
      FS_WAIT: begin
        if (IMEM_ACK) begin
          if (LOAD_PC) begin
            pc_load = 1'b1;
          end else if (pend_vld) begin
            pc_load = 1'b1;
            pc_d    = pend_pc;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_VEC(RESET_VEC)
  ) u_pc (
    .CLK     (CLK),
    .RST     (RST),
    .load    (pc_load),
    .load_val(pc_d),
    .inc     (pc_inc),
    .pc      (PC)
  );

  // Pending redirect target is plain data; its validity lives in pend_vld
  always_ff @(posedge CLK) begin
    if (state == FS_WAIT && !IMEM_ACK && LOAD_PC) pend_pc <= PC_IN;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= FS_IDLE;
      IR          <= '0;
      IR_PC       <= '0;
      INSTR_VALID <= 1'b0;
      IMEM_REQ    <= 1'b0;
      IMEM_ADDR   <= '0;
      BUSY        <= 1'b0;
      FAULT       <= 1'b0;
      tmo_cnt     <= '0;
      pend_vld    <= 1'b0;
    end else begin
      case (state)
        FS_IDLE: begin
          if (EN) begin
            if (FETCH) begin
              state       <= FS_WAIT;
              BUSY        <= 1'b1;
              IMEM_REQ    <= 1'b1;
              IMEM_ADDR   <= LOAD_PC ? PC_IN : PC;
              INSTR_VALID <= 1'b0;
              tmo_cnt     <= '0;
              pend_vld    <= 1'b0;
            end else if (LOAD_PC) begin
              INSTR_VALID <= 1'b0;
            end
          end
        end

        FS_WAIT: begin
          if (IMEM_ACK) begin
            if (!drop_data) begin
              IR          <= IMEM_RDATA;
              IR_PC       <= PC;
              INSTR_VALID <= 1'b1;
            end
            IMEM_REQ <= 1'b0;
            BUSY     <= 1'b0;
            pend_vld <= 1'b0;
            state    <= FS_IDLE;
          end else begin
            if (LOAD_PC) pend_vld <= 1'b1;
            // Fault is taken on the wait cycle after the counter has
            // already reached TIMEOUT, so an ACK there still completes.
            if (TIMEOUT != 0 && tmo_cnt == CNT_MAX) begin
              state       <= FS_FAULT;
              IMEM_REQ    <= 1'b0;
              BUSY        <= 1'b0;
              FAULT       <= 1'b1;
              INSTR_VALID <= 1'b0;
            end else if (TIMEOUT != 0) begin
              tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
          end
        end

        FS_FAULT: begin
          // Only RST leaves this state
          IMEM_REQ    <= 1'b0;
          BUSY        <= 1'b0;
          FAULT       <= 1'b1;
          INSTR_VALID <= 1'b0;
        end

        default: begin
          state <= FS_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
